// File: rtl/speed_counter_pkg.sv
// rtl/speed_counter_pkg.sv - shared types and rate helpers for speed_counter
package speed_counter_pkg;

    typedef enum logic {
        WRAP     = 1'b0,
        SATURATE = 1'b1
    } mode_e;

    // Period(0) is a single cycle; each further step doubles from the base period.
    function automatic int unsigned period_of(input int unsigned clock_frequency,
                                              input int unsigned k);
        if (k == 0) begin
            return 1;
        end
        return clock_frequency << (k - 1);
    endfunction

endpackage

// File: rtl/speed_counter_if.sv
// rtl/speed_counter_if.sv - control/status bundle between speed_counter and its driver
interface speed_counter_if
    import speed_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int SPEED_W = 2
) ();

    logic [SPEED_W-1:0] Speed;
    logic               Enable;
    logic               Up;
    mode_e              Mode;
    logic               Load;
    logic [WIDTH-1:0]   LoadValue;
    logic [WIDTH-1:0]   MaxCount;
    logic [WIDTH-1:0]   CounterValue;
    logic               Tick;
    logic               Terminal;

    modport master (
        output Speed, Enable, Up, Mode, Load, LoadValue, MaxCount,
        input  CounterValue, Tick, Terminal
    );

    modport slave (
        input  Speed, Enable, Up, Mode, Load, LoadValue, MaxCount,
        output CounterValue, Tick, Terminal
    );

endinterface

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - programmable-period divider producing the count-step strobe
module tick_gen
    import speed_counter_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 500,
    parameter int SPEED_W         = 2
) (
    input  logic               ClockIn,
    input  logic               ResetN,
    input  logic [SPEED_W-1:0] Speed,
    input  logic               Enable,
    input  logic               Load,
    output logic               Tick
);

    localparam int NUM_SPEEDS = 2 ** SPEED_W;
    // Sized for the slowest rate so Period-1 is never truncated.
    localparam int DIV_W      = $clog2(CLOCK_FREQUENCY << (NUM_SPEEDS - 2)) + 1;

    logic [DIV_W-1:0] div_count;
    logic [DIV_W-1:0] div_next;
    logic [DIV_W-1:0] reload_value;

    always_comb begin
        reload_value = '0;
        for (int k = 0; k < NUM_SPEEDS; k++) begin
            if (Speed == SPEED_W'(k)) begin
                reload_value = DIV_W'(period_of(CLOCK_FREQUENCY, k) - 1);
            end
        end
    end

    assign Tick = ResetN & Enable & ~Load & (div_count == '0);

    // Speed is only sampled at reload, so a mid-period change never restarts the period.
    always_comb begin
        div_next = div_count;
        if (Load || Tick) begin
            div_next = reload_value;
        end else if (Enable) begin
            div_next = div_count - DIV_W'(1);
        end
    end

    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            div_count <= '0;
        end else begin
            div_count <= div_next;
        end
    end

endmodule

// File: rtl/speed_counter.sv
// rtl/speed_counter.sv - rate-selectable up/down counter with wrap/saturate bounds
module speed_counter
    import speed_counter_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 500,
    parameter int WIDTH           = 4,
    parameter int SPEED_W         = 2
) (
    input  logic            ClockIn,
    input  logic            ResetN,
    speed_counter_if.slave  bus
);

    logic             tick;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_next;
    logic             terminal_q;
    logic             terminal_next;

    tick_gen #(
        .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
        .SPEED_W         (SPEED_W)
    ) u_tick_gen (
        .ClockIn (ClockIn),
        .ResetN  (ResetN),
        .Speed   (bus.Speed),
        .Enable  (bus.Enable),
        .Load    (bus.Load),
        .Tick    (tick)
    );

    always_comb begin
        count_next    = count_q;
        terminal_next = 1'b0;
        if (bus.Load) begin
            count_next = (bus.LoadValue > bus.MaxCount) ? bus.MaxCount : bus.LoadValue;
        end else if (tick) begin
            if (bus.Up) begin
                if (count_q < bus.MaxCount) begin
                    count_next = count_q + WIDTH'(1);
                end else begin
                    count_next    = (bus.Mode == SATURATE) ? bus.MaxCount : '0;
                    terminal_next = 1'b1;
                end
            end else begin
                // A count stranded above a lowered bound is pulled back without a boundary event.
                if (count_q > bus.MaxCount) begin
                    count_next = bus.MaxCount;
                end else if (count_q == '0) begin
                    count_next    = (bus.Mode == SATURATE) ? '0 : bus.MaxCount;
                    terminal_next = 1'b1;
                end else begin
                    count_next = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            count_q    <= '0;
            terminal_q <= 1'b0;
        end else begin
            count_q    <= count_next;
            terminal_q <= terminal_next;
        end
    end

    assign bus.CounterValue = count_q;
    assign bus.Terminal     = terminal_q;
    assign bus.Tick         = tick;

endmodule

// File: tb/tb_speed_counter.sv
// tb/tb_speed_counter.sv - self-checking bench for speed_counter
module tb_speed_counter;
    import speed_counter_pkg::*;

    localparam int CF = 4;
    localparam int W  = 4;
    localparam int SW = 2;

    logic ClockIn = 1'b0;
    logic ResetN  = 1'b0;

    speed_counter_if #(.WIDTH(W), .SPEED_W(SW)) bus ();

    speed_counter #(.CLOCK_FREQUENCY(CF), .WIDTH(W), .SPEED_W(SW)) dut (
        .ClockIn (ClockIn),
        .ResetN  (ResetN),
        .bus     (bus)
    );

    always #5 ClockIn = ~ClockIn;

    int checks   = 0;
    int failures = 0;

    // Reference state: step index of enabled cycles and the index at which the next step is due.
    int m_count = 0;
    bit m_term  = 1'b0;
    int m_now   = 0;
    int m_due   = 0;
    bit m_tick  = 1'b0;
    bit obs_tick = 1'b0;

    function automatic int ref_period(input int k);
        return (k == 0) ? 1 : (CF << (k - 1));
    endfunction

    function automatic void ref_rule(input int c, input bit up, input bit sat, input int mx,
                                     output int nc, output bit t);
        nc = c;
        t  = 1'b0;
        if (up) begin
            if (c < mx) nc = c + 1;
            else begin nc = sat ? mx : 0; t = 1'b1; end
        end else begin
            if (c > mx) nc = mx;
            else if (c == 0) begin nc = sat ? 0 : mx; t = 1'b1; end
            else nc = c - 1;
        end
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_term  = 1'b0;
        m_due   = m_now;
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic step();
        int spd, lv, mx, nc;
        bit en, ld, up, sat, t;
        #1;
        spd = int'(bus.Speed);
        en  = bus.Enable;
        ld  = bus.Load;
        up  = bus.Up;
        sat = (bus.Mode == SATURATE);
        lv  = int'(bus.LoadValue);
        mx  = int'(bus.MaxCount);
        m_tick   = ResetN && en && !ld && (m_now == m_due);
        obs_tick = bus.Tick;
        @(posedge ClockIn);
        m_term = 1'b0;
        if (ld) begin
            m_count = (lv > mx) ? mx : lv;
            m_due   = m_now + ref_period(spd) - 1;
        end else if (en) begin
            if (m_now == m_due) begin
                ref_rule(m_count, up, sat, mx, nc, t);
                m_count = nc;
                m_term  = t;
                m_due   = m_now + ref_period(spd);
            end
            m_now++;
        end
        @(negedge ClockIn);
    endtask

    task automatic load_value(input int v);
        bus.Load = 1'b1;
        bus.LoadValue = W'(v);
        step();
        bus.Load = 1'b0;
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        bus.Speed = '0; bus.Enable = 1'b1; bus.Up = 1'b1; bus.Mode = WRAP;
        bus.Load = 1'b0; bus.LoadValue = '0; bus.MaxCount = W'(9);
        repeat (2) @(negedge ClockIn);
        #1;
        checks++; if (bus.CounterValue !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.CounterValue); end
        checks++; if (bus.Terminal !== 1'b0) begin failures++; $display("FAIL reset_terminal got=%b exp=0", bus.Terminal); end
        checks++; if (bus.Tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", bus.Tick); end
        ResetN = 1'b1;
        model_reset();
        step();
        checks++; if (obs_tick !== 1'b1) begin failures++; $display("FAIL first_tick got=%b exp=1", obs_tick); end
        checks++; if (bus.CounterValue !== W'(1)) begin failures++; $display("FAIL first_count got=%0d exp=1", bus.CounterValue); end
    endtask

    task automatic test_wrap_sequence();
        bus.Speed = '0; bus.Up = 1'b1; bus.Mode = WRAP; bus.MaxCount = W'(9); bus.Enable = 1'b1;
        load_value(0);
        for (int i = 0; i < 11; i++) begin
            step();
            checks++; if (bus.CounterValue !== W'((i + 1) % 10)) begin failures++; $display("FAIL wrap_count i=%0d got=%0d exp=%0d", i, bus.CounterValue, (i + 1) % 10); end
            checks++; if (bus.Terminal !== (i == 9)) begin failures++; $display("FAIL wrap_terminal i=%0d got=%b exp=%b", i, bus.Terminal, (i == 9)); end
            checks++; if (obs_tick !== 1'b1) begin failures++; $display("FAIL wrap_tick i=%0d got=%b exp=1", i, obs_tick); end
        end
    endtask

    task automatic test_speed_switch();
        int ticks[$];
        int exp_ticks[3] = '{8, 12, 16};
        bus.Speed = SW'(2); bus.Up = 1'b1; bus.Mode = WRAP; bus.MaxCount = W'(15); bus.Enable = 1'b1;
        load_value(0);
        for (int i = 1; i <= 16; i++) begin
            if (i == 4) bus.Speed = SW'(1);
            step();
            if (obs_tick) ticks.push_back(i);
            checks++; if (obs_tick !== m_tick) begin failures++; $display("FAIL switch_tick i=%0d got=%b exp=%b", i, obs_tick, m_tick); end
            checks++; if (bus.CounterValue !== W'(m_count)) begin failures++; $display("FAIL switch_count i=%0d got=%0d exp=%0d", i, bus.CounterValue, m_count); end
        end
        checks++;
        if (ticks.size() != 3) begin
            failures++; $display("FAIL switch_tick_count got=%0d exp=3", ticks.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (ticks[j] != exp_ticks[j]) begin failures++; $display("FAIL switch_tick_pos j=%0d got=%0d exp=%0d", j, ticks[j], exp_ticks[j]); break; end
            end
        end
    endtask

    task automatic test_load_saturate_down();
        int exp_c[5] = '{2, 1, 0, 0, 0};
        bit exp_t[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.Speed = '0; bus.Up = 1'b0; bus.Mode = SATURATE; bus.MaxCount = W'(9); bus.Enable = 1'b1;
        load_value(3);
        checks++; if (obs_tick !== 1'b0) begin failures++; $display("FAIL load_tick got=%b exp=0", obs_tick); end
        checks++; if (bus.CounterValue !== W'(3)) begin failures++; $display("FAIL load_count got=%0d exp=3", bus.CounterValue); end
        checks++; if (bus.Terminal !== 1'b0) begin failures++; $display("FAIL load_terminal got=%b exp=0", bus.Terminal); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (bus.CounterValue !== W'(exp_c[i])) begin failures++; $display("FAIL satdown_count i=%0d got=%0d exp=%0d", i, bus.CounterValue, exp_c[i]); end
            checks++; if (bus.Terminal !== exp_t[i]) begin failures++; $display("FAIL satdown_terminal i=%0d got=%b exp=%b", i, bus.Terminal, exp_t[i]); end
        end
        load_value(12);
        checks++; if (bus.CounterValue !== W'(9)) begin failures++; $display("FAIL load_clamp got=%0d exp=9", bus.CounterValue); end
    endtask

    task automatic test_enable_pause();
        int ticks[$];
        int exp_ticks[3] = '{4, 13, 17};
        bus.Speed = SW'(1); bus.Up = 1'b1; bus.Mode = WRAP; bus.MaxCount = W'(9); bus.Enable = 1'b1;
        load_value(0);
        for (int i = 1; i <= 18; i++) begin
            bus.Enable = !(i >= 6 && i <= 10);
            step();
            if (obs_tick) ticks.push_back(i);
            checks++; if (obs_tick !== m_tick) begin failures++; $display("FAIL pause_tick i=%0d got=%b exp=%b", i, obs_tick, m_tick); end
            checks++; if (bus.CounterValue !== W'(m_count)) begin failures++; $display("FAIL pause_count i=%0d got=%0d exp=%0d", i, bus.CounterValue, m_count); end
        end
        bus.Enable = 1'b1;
        checks++;
        if (ticks.size() != 3) begin
            failures++; $display("FAIL pause_tick_count got=%0d exp=3", ticks.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (ticks[j] != exp_ticks[j]) begin failures++; $display("FAIL pause_tick_pos j=%0d got=%0d exp=%0d", j, ticks[j], exp_ticks[j]); break; end
            end
        end
    endtask

    task automatic test_max_lowered();
        int exp_c[3] = '{0, 5, 5};
        bit exp_t[3] = '{1'b1, 1'b1, 1'b0};
        bus.Speed = '0; bus.Enable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.MaxCount = W'(9);
            load_value(8);
            bus.MaxCount = W'(5);
            bus.Up   = (c != 2);
            bus.Mode = (c == 1) ? SATURATE : WRAP;
            step();
            checks++; if (bus.CounterValue !== W'(exp_c[c])) begin failures++; $display("FAIL lowered_count case=%0d got=%0d exp=%0d", c, bus.CounterValue, exp_c[c]); end
            checks++; if (bus.Terminal !== exp_t[c]) begin failures++; $display("FAIL lowered_terminal case=%0d got=%b exp=%b", c, bus.Terminal, exp_t[c]); end
        end
    endtask

    task automatic test_maxcount_zero();
        bus.Speed = '0; bus.Enable = 1'b1; bus.MaxCount = '0;
        load_value(7);
        for (int i = 0; i < 4; i++) begin
            bus.Up   = (i < 2);
            bus.Mode = i[0] ? SATURATE : WRAP;
            step();
            checks++; if (bus.CounterValue !== '0) begin failures++; $display("FAIL zero_count i=%0d got=%0d exp=0", i, bus.CounterValue); end
            checks++; if (bus.Terminal !== 1'b1) begin failures++; $display("FAIL zero_terminal i=%0d got=%b exp=1", i, bus.Terminal); end
        end
    endtask

    task automatic test_async_reset();
        bus.Speed = '0; bus.Up = 1'b1; bus.Mode = WRAP; bus.MaxCount = W'(9); bus.Enable = 1'b1;
        load_value(7);
        bus.Enable = 1'b0;
        #2 ResetN = 1'b0;
        #1;
        checks++; if (bus.CounterValue !== '0) begin failures++; $display("FAIL async_count got=%0d exp=0", bus.CounterValue); end
        checks++; if (bus.Tick !== 1'b0) begin failures++; $display("FAIL async_tick got=%b exp=0", bus.Tick); end
        #1 ResetN = 1'b1;
        model_reset();
        @(negedge ClockIn);
        bus.Enable = 1'b1;
        step();
        checks++; if (obs_tick !== 1'b1) begin failures++; $display("FAIL post_reset_tick got=%b exp=1", obs_tick); end
        checks++; if (bus.CounterValue !== W'(1)) begin failures++; $display("FAIL post_reset_count got=%0d exp=1", bus.CounterValue); end
        load_value(9);
        step();
        checks++; if (bus.Terminal !== 1'b1) begin failures++; $display("FAIL pending_terminal_setup got=%b exp=1", bus.Terminal); end
        bus.Enable = 1'b0;
        #2 ResetN = 1'b0;
        #1;
        checks++; if (bus.Terminal !== 1'b0) begin failures++; $display("FAIL async_terminal got=%b exp=0", bus.Terminal); end
        #1 ResetN = 1'b1;
        model_reset();
        @(negedge ClockIn);
        bus.Enable = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            bus.Enable    = ($urandom_range(0, 7) != 0);
            bus.Load      = ($urandom_range(0, 15) == 0);
            bus.LoadValue = W'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) bus.Speed = SW'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) bus.Up = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) bus.Mode = mode_e'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) bus.MaxCount = W'($urandom_range(0, 15));
            step();
            checks++; if (obs_tick !== m_tick) begin failures++; $display("FAIL rand_tick i=%0d got=%b exp=%b", i, obs_tick, m_tick); end
            checks++; if (bus.CounterValue !== W'(m_count)) begin failures++; $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, bus.CounterValue, m_count); end
            checks++; if (bus.Terminal !== m_term) begin failures++; $display("FAIL rand_terminal i=%0d got=%b exp=%b", i, bus.Terminal, m_term); end
        end
        bus.Load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_sequence();
        test_speed_switch();
        test_load_saturate_down();
        test_enable_pause();
        test_max_lowered();
        test_maxcount_zero();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/speed_counter.md
SPEED_COUNTER -- requirements
Module: speed_counter

Interface
REQ-001 Parameter CLOCK_FREQUENCY, default 500: ClockIn cycles per base period (Speed=1).
REQ-002 Parameter WIDTH, default 4: CounterValue width.
REQ-003 Parameter SPEED_W, default 2: Speed width.
REQ-004 ClockIn  input  1  single clock; all state on rising edge.
REQ-005 ResetN  input  1  asynchronous, active-low reset.
REQ-006 Speed  input  SPEED_W  rate select; Period(0)=1, Period(k)=CLOCK_FREQUENCY<<(k-1) for k>=1.
REQ-007 Enable  input  1  1=run, 0=pause (divider and counter hold).
REQ-008 Up  input  1  1=count up, 0=count down.
REQ-009 Mode  input  1  0=WRAP, 1=SATURATE.
REQ-010 Load  input  1  synchronous load strobe.
REQ-011 LoadValue  input  WIDTH  value for Load.
REQ-012 MaxCount  input  WIDTH  upper count bound, inclusive.
REQ-013 CounterValue  output  WIDTH  registered count.
REQ-014 Tick  output  1  combinational; high in each cycle a count step occurs.
REQ-015 Terminal  output  1  registered one-cycle pulse on a boundary event.

Function
REQ-016 Divider DivCount SHALL have width $clog2(CLOCK_FREQUENCY<<(2**SPEED_W-2))+1 and never truncate Period-1.
REQ-017 Tick SHALL equal Enable & ~Load & (DivCount==0).
REQ-018 On Tick, DivCount SHALL reload Period(Speed)-1, Speed sampled that cycle; otherwise, if Enable=1 and Load=0, DivCount SHALL decrement by 1.
REQ-019 With Enable=0 and Load=0, DivCount and CounterValue SHALL hold.
REQ-020 Speed changes mid-period SHALL NOT restart the period; the new Speed applies from the next reload.
REQ-021 Load=1 SHALL set CounterValue to min(LoadValue, MaxCount) and DivCount to Period(Speed)-1 next edge, regardless of Enable; no Tick and no Terminal that cycle.
REQ-022 Up tick, CounterValue<MaxCount: CounterValue+1.
REQ-023 Up tick, CounterValue>=MaxCount: WRAP -> 0; SATURATE -> MaxCount; Terminal=1 next cycle.
REQ-024 Down tick, 0<CounterValue<=MaxCount: CounterValue-1.
REQ-025 Down tick, CounterValue==0: WRAP -> MaxCount; SATURATE -> hold 0; Terminal=1 next cycle.
REQ-026 Down tick, CounterValue>MaxCount (MaxCount lowered): CounterValue -> MaxCount in both modes; no Terminal.
REQ-027 Terminal SHALL be high exactly one cycle per boundary event, concurrent with the updated CounterValue; repeats on every saturated tick.
REQ-028 MaxCount=0 SHALL keep CounterValue at 0 with Terminal on every tick.

Reset
REQ-029 ResetN low SHALL immediately clear CounterValue, DivCount and Terminal to 0 regardless of ClockIn.
REQ-030 Tick SHALL be 0 during reset; first Tick occurs in the first cycle after release with Enable=1, Load=0.
REQ-031 Reset asserted mid-period SHALL discard partial period and any pending Terminal.

Structure
REQ-032 Package speed_counter_pkg SHALL hold the mode_e enum (WRAP, SATURATE) and a constant function for Period(k).
REQ-033 Divider SHALL be sub-module tick_gen (ClockIn, ResetN, Speed, Enable, Load -> Tick); the count/boundary logic stays in speed_counter.

Verification (CLOCK_FREQUENCY=4, WIDTH=4, SPEED_W=2)
REQ-034 Speed=0, Up, WRAP, MaxCount=9, Enable=1 -> CounterValue 0..9,0 one step per cycle; Terminal high only in the cycle CounterValue returns to 0.
REQ-035 Speed=2 -> Tick every 8 cycles; switch to Speed=1 at cycle 3 of a period -> that period still ends at 8, following ticks every 4.
REQ-036 Load, LoadValue=3, Down, SATURATE, Speed=0 -> 3,2,1,0,0,0; Terminal on each tick at 0; LoadValue=12 with MaxCount=9 loads 9.
REQ-037 Enable low for 5 cycles mid-period at Speed=1 -> CounterValue and Tick spacing resume with period extended by exactly 5 cycles.
REQ-038 CounterValue=8, MaxCount lowered to 5: Up tick -> 0 (WRAP) or 5 (SATURATE) with Terminal; Down tick -> 5, no Terminal.
REQ-039 ResetN pulsed low between edges at CounterValue=7 -> CounterValue=0, Terminal=0 before next edge; first post-release Tick counts to 1.
